// File: rtl/sad_window_accumulator.sv
// sad_window_accumulator
// Sums |pix_a - pix_b| over WINDOW accepted pairs into a saturating 8-bit
// total, then holds the result (with spike and saturation flags) until the
// downstream side takes it. A one-deep difference register sits in front of
// the accumulator, so the last pair needs an extra DRAIN cycle to land.
module sad_window_accumulator #(
  parameter int WINDOW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_a,
  input  logic [7:0] pix_b,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] thresh,
  output logic [7:0] sad_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       spike,
  output logic       sat_flag
);

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] d1;
  logic       v1;
  logic [7:0] acc;
  logic       sat_bit;
  logic       accept;
  logic       last_pair;
  logic       clip;
  logic [7:0] acc_sum;

  // Absolute difference taken from a 9-bit two's-complement subtraction.
  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] diff;
    logic signed [8:0] mag;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = diff[8] ? -diff : diff;
    return mag[7:0];
  endfunction

  // Saturating 8-bit add; the MSB of the return value flags a clip.
  function automatic logic [8:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? {1'b1, 8'hFF} : {1'b0, sum[7:0]};
  endfunction

  assign accept    = in_valid && in_ready;
  assign last_pair = accept && (cnt == LAST_IDX);
  assign {clip, acc_sum} = v1 ? sat_add(acc, d1) : {1'b0, acc};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (last_pair) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Difference stage, accumulator, and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      d1        <= '0;
      v1        <= 1'b0;
      acc       <= '0;
      sat_bit   <= 1'b0;
      sad_out   <= '0;
      spike     <= 1'b0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1      <= accept;
      acc     <= acc_sum;
      sat_bit <= sat_bit | clip;
      if (accept) begin
        d1  <= abs_diff(pix_a, pix_b);
        cnt <= cnt + 8'd1;
      end
      // The DRAIN edge folds in the final difference and publishes the result.
      if (state == DRAIN) begin
        sad_out   <= acc_sum;
        spike     <= (acc_sum >= thresh);
        sat_flag  <= sat_bit | clip;
        out_valid <= 1'b1;
      end
      // Handshake: start the next window from zero; result outputs keep their values.
      if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
        acc       <= '0;
        cnt       <= '0;
        sat_bit   <= 1'b0;
        v1        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sad_window_accumulator.sv
// Directed bench for sad_window_accumulator with WINDOW=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sad_window_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_a;
  logic [7:0] pix_b;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] thresh;
  logic [7:0] sad_out;
  logic       out_valid;
  logic       out_ready;
  logic       spike;
  logic       sat_flag;

  int total = 0;
  int bad   = 0;

  sad_window_accumulator #(.WINDOW(4)) dut (
    .clk(clk), .rst_n(rst_n), .pix_a(pix_a), .pix_b(pix_b),
    .in_valid(in_valid), .in_ready(in_ready), .thresh(thresh),
    .sad_out(sad_out), .out_valid(out_valid), .out_ready(out_ready),
    .spike(spike), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Present a pair for n consecutive cycles, then drop in_valid.
  task automatic send_pairs(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      pix_a = a; pix_b = b; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Single-cycle out_ready pulse.
  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Wait the DRAIN cycle, then check latency and the published result.
  task automatic check_result(input string name, input logic [7:0] exp_sad,
                              input logic exp_spike, input logic exp_sat);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: out_valid=%b in_ready=%b required 0 0", name, out_valid, in_ready);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || sad_out !== exp_sad || spike !== exp_spike || sat_flag !== exp_sat) begin
      bad++;
      $display("FAIL %s_result: ov=%b sad=%0d spike=%b sat=%b required 1 %0d %b %b",
               name, out_valid, sad_out, spike, sat_flag, exp_sad, exp_spike, exp_sat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_a = 0; pix_b = 0; in_valid = 0; out_ready = 0; thresh = 0;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || sad_out !== 8'd0 || spike !== 1'b0 || sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: ov=%b sad=%0d spike=%b sat=%b required all 0",
               out_valid, sad_out, spike, sat_flag);
    end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    thresh = 8'd20;
    send_pairs(8'd10, 8'd3, 4);
    check_result("basic", 8'd28, 1'b1, 1'b0);
    handshake();
    total++;
    if (out_valid !== 1'b0 || sad_out !== 8'd28 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_after_hs: ov=%b sad=%0d in_ready=%b required 0 28 1",
               out_valid, sad_out, in_ready);
    end
  endtask

  task automatic test_symmetry();
    thresh = 8'd29;
    send_pairs(8'd3, 8'd10, 4);
    check_result("sym_t29", 8'd28, 1'b0, 1'b0);
    handshake();
    thresh = 8'd28;
    send_pairs(8'd3, 8'd10, 4);
    check_result("sym_t28", 8'd28, 1'b1, 1'b0);
    handshake();
  endtask

  task automatic test_saturation();
    thresh = 8'd255;
    send_pairs(8'd255, 8'd0, 4);
    check_result("sat_full", 8'd255, 1'b1, 1'b1);
    handshake();
    send_pairs(8'd1, 8'd0, 4);
    check_result("sat_clear", 8'd4, 1'b0, 1'b0);
    handshake();
  endtask

  task automatic test_hold_stall();
    thresh = 8'd20;
    send_pairs(8'd10, 8'd3, 4);
    check_result("stall", 8'd28, 1'b1, 1'b0);
    pix_a = 8'd100; pix_b = 8'd0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || sad_out !== 8'd28 || spike !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold_%0d: in_ready=%b ov=%b sad=%0d spike=%b required 0 1 28 1",
                 i, in_ready, out_valid, sad_out, spike);
      end
    end
    handshake();
    send_pairs(8'd2, 8'd1, 4);
    check_result("stall_next", 8'd4, 1'b0, 1'b0);
    handshake();
  endtask

  task automatic test_reset_mid();
    thresh = 8'd5;
    send_pairs(8'd50, 8'd0, 2);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || sad_out !== 8'd0 || spike !== 1'b0 || sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: ov=%b sad=%0d spike=%b sat=%b required all 0",
               out_valid, sad_out, spike, sat_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_pairs(8'd1, 8'd2, 4);
    check_result("midreset", 8'd4, 1'b0, 1'b0);
    handshake();
  endtask

  task automatic test_gaps();
    logic pattern [7];
    int   ov_cycles;
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    thresh = 8'd20; out_ready = 1'b1; pix_a = 8'd9; pix_b = 8'd4;
    for (int i = 0; i < 7; i++) begin
      in_valid = pattern[i];
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    check_result("gaps", 8'd20, 1'b1, 1'b0);
    ov_cycles = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid === 1'b1) ov_cycles++;
    end
    total++;
    if (ov_cycles !== 1) begin
      bad++;
      $display("FAIL gaps_one_cycle: out_valid cycles=%0d required 1", ov_cycles);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_symmetry();
    test_saturation();
    test_hold_stall();
    test_reset_mid();
    test_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
